// File: rtl/compress_stream_ctrl.sv
// compress_stream_ctrl: polynomial read sequencer with hold/replay and optional write-back address generation
package compress_stream_ctrl_pkg;
  localparam int ABR_MEM_ADDR_WIDTH = 15;
  localparam int MLKEM_N = 256;
  typedef enum logic [1:0] {RW_IDLE = 2'd0, RW_READ = 2'd1, RW_WRITE = 2'd2} rw_e;
  typedef struct packed {
    rw_e rd_wr_en;
    logic [ABR_MEM_ADDR_WIDTH-1:0] addr;
  } mem_if_t;
endpackage

module compress_stream_ctrl
  import compress_stream_ctrl_pkg::*;
#(
  parameter int ADDR_W = ABR_MEM_ADDR_WIDTH,
  parameter int RD_WORDS_PER_POLY = MLKEM_N / 4,
  parameter int WR_WORDS_PER_POLY = 32,
  parameter int MAX_POLY = 4,
  parameter int NP_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              zeroize,
  input  logic              cmp_enable,
  input  logic              wb_mode,
  input  logic [NP_W-1:0]   num_poly,
  input  logic [ADDR_W-1:0] src_base_addr,
  input  logic [ADDR_W-1:0] dst_base_addr,
  output mem_if_t           mem_rd_req,
  output logic              mem_rd_data_valid,
  input  logic              mem_rd_data_hold,
  output logic [NP_W-1:0]   poly_idx,
  output logic              last_word,
  input  logic              wr_data_valid,
  output mem_if_t           mem_wr_req,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int AW = ABR_MEM_ADDR_WIDTH;
  localparam int RW_W = $clog2(RD_WORDS_PER_POLY + 1);
  localparam int WC_W = $clog2(MAX_POLY * WR_WORDS_PER_POLY + 1);
  localparam logic [RW_W-1:0] WMAX = RW_W'(RD_WORDS_PER_POLY - 1);

  typedef enum logic [1:0] {IDLE, RD, DRAIN} state_e;

  state_e state;
  logic wb_q;
  logic [NP_W-1:0] np_q, poly;
  logic [RW_W-1:0] word;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [WC_W-1:0] wr_count, wr_total;
  logic rd_on, last_rd, wr_fire, wr_done, legal, word_wrap;

  assign rd_on = state == RD;
  assign word_wrap = word == WMAX;
  assign last_rd = rd_on && !mem_rd_data_hold && poly == np_q - 1'b1 && word_wrap;
  assign wr_total = WC_W'(np_q) * WC_W'(WR_WORDS_PER_POLY);
  assign wr_fire = wb_q && state != IDLE && wr_data_valid && wr_count < wr_total;
  assign wr_done = wr_count + WC_W'(wr_fire) == wr_total;
  assign legal = num_poly != '0 && num_poly <= NP_W'(MAX_POLY);

  assign mem_rd_req = '{rd_wr_en: rd_on ? RW_READ : RW_IDLE, addr: rd_on ? AW'(rd_addr) : '0};
  assign mem_wr_req = '{rd_wr_en: wr_fire ? RW_WRITE : RW_IDLE, addr: wr_fire ? AW'(wr_addr) : '0};
  assign poly_idx = poly;
  assign last_word = rd_on && word_wrap;
  assign done = state == IDLE;
  assign busy = !done;

  // Sequencer: config latch at start, read stepping with hold replay, write counting, exit decisions
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      {wb_q, np_q, poly, word, rd_addr, wr_addr, wr_count, mem_rd_data_valid, err} <= '0;
    end else if (zeroize) begin
      state <= IDLE;
      {wb_q, np_q, poly, word, rd_addr, wr_addr, wr_count, mem_rd_data_valid, err} <= '0;
    end else begin
      err <= state == IDLE && cmp_enable && !legal;
      mem_rd_data_valid <= rd_on;
      if (state == IDLE) begin
        if (cmp_enable && legal) begin
          state <= RD;
          wb_q <= wb_mode;
          np_q <= num_poly;
          rd_addr <= src_base_addr;
          wr_addr <= dst_base_addr;
          {poly, word, wr_count} <= '0;
        end
      end else begin
        if (wr_fire) begin
          wr_addr <= wr_addr + 1'b1;
          wr_count <= wr_count + 1'b1;
        end
        if (rd_on && !mem_rd_data_hold) begin
          rd_addr <= rd_addr + 1'b1;
          word <= word_wrap ? '0 : word + 1'b1;
          if (word_wrap && !last_rd) poly <= poly + 1'b1;
        end
        if (last_rd) state <= (wb_q && !wr_done) ? DRAIN : IDLE;
        if (state == DRAIN && wr_done) state <= IDLE;
      end
    end
  end
endmodule
